// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Runs loads/stores from the EX/MEM bundle
// against data memory, stalls upstream while an access is outstanding and
// registers the MEM/WB result for write-back.
//
// Handshake: dmem_req rises on the edge after an aligned memory op is seen.
// It stays high, with addr/we/be/wdata held constant, until the cycle in
// which dmem_ack is sampled high. A transfer completes on the edge that ends
// that cycle. dmem_rdata is only sampled in that same cycle. dmem_ack is
// ignored whenever no request is outstanding. With TIMEOUT != 0, a request
// left unacknowledged for TIMEOUT cycles is dropped and bus_err is raised.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        exm_valid,
  input  logic [31:0] exm_alu_result,
  input  logic [31:0] exm_store_data,
  input  logic [4:0]  exm_rd,
  input  logic        exm_reg_write,
  input  logic        exm_mem_read,
  input  logic        exm_mem_write,
  input  logic [1:0]  exm_size,
  input  logic        exm_unsigned,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mwb_valid,
  output logic [4:0]  mwb_rd,
  output logic        mwb_reg_write,
  output logic [31:0] mwb_wb_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        state_dbg
);

  // The wait counter holds 0..TIMEOUT-1; reaching the last value without ack
  // means this is the TIMEOUT-th unacknowledged request cycle.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [4:0]    lat_rd;
  logic [1:0]    lat_size;
  logic [1:0]    lat_off;
  logic          lat_uns;
  logic          lat_reg_write;

  logic          mem_op, misaligned, launch, bad, timeout;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new, shifted, load_data;

  assign mem_op    = exm_valid & (exm_mem_read | exm_mem_write);
  assign state_dbg = (state == REQ);

  // Decode alignment, byte enables and lane-replicated store data of the bundle.
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = exm_store_data;
    case (exm_size)
      2'b00: begin
        be_new    = 4'b0001 << exm_alu_result[1:0];
        wdata_new = {4{exm_store_data[7:0]}};
      end
      2'b01: begin
        misaligned = exm_alu_result[0];
        be_new     = 4'b0011 << exm_alu_result[1:0];
        wdata_new  = {2{exm_store_data[15:0]}};
      end
      2'b10:   misaligned = |exm_alu_result[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Align returned read data to bit 0 and extend to 32 bits.
  always_comb begin
    shifted = dmem_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'b00:   load_data = lat_uns ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = lat_uns ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Next state, stall and per-cycle event decode.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    bad        = 1'b0;
    timeout    = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        launch = mem_op & ~misaligned;
        bad    = mem_op & misaligned;
        stall  = launch;
        if (launch) state_next = REQ;
      end
      REQ: begin
        timeout = (TIMEOUT != 0) && !dmem_ack && (cnt == CNT_LAST);
        stall   = !dmem_ack && !timeout;
        if (dmem_ack || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, memory request registers and MEM/WB result register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      lat_rd        <= '0;
      lat_size      <= '0;
      lat_off       <= '0;
      lat_uns       <= 1'b0;
      lat_reg_write <= 1'b0;
      mwb_valid     <= 1'b0;
      mwb_rd        <= '0;
      mwb_reg_write <= 1'b0;
      mwb_wb_data   <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state         <= state_next;
      mwb_valid     <= 1'b0;
      mwb_reg_write <= 1'b0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (launch) begin
            dmem_req      <= 1'b1;
            dmem_we       <= exm_mem_write;
            dmem_addr     <= {exm_alu_result[31:2], 2'b00};
            dmem_be       <= be_new;
            dmem_wdata    <= wdata_new;
            lat_rd        <= exm_rd;
            lat_size      <= exm_size;
            lat_off       <= exm_alu_result[1:0];
            lat_uns       <= exm_unsigned;
            lat_reg_write <= exm_reg_write;
          end else if (bad) begin
            // Faulting access retires as a no-write bundle flagged with the error.
            mwb_valid    <= 1'b1;
            mwb_rd       <= exm_rd;
            mwb_wb_data  <= exm_alu_result;
            misalign_err <= 1'b1;
          end else if (exm_valid) begin
            mwb_valid     <= 1'b1;
            mwb_rd        <= exm_rd;
            mwb_reg_write <= exm_reg_write;
            mwb_wb_data   <= exm_alu_result;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            cnt           <= '0;
            mwb_valid     <= 1'b1;
            mwb_rd        <= lat_rd;
            mwb_reg_write <= !dmem_we && lat_reg_write;
            mwb_wb_data   <= dmem_we ? 32'h0 : load_data;
          end else if (timeout) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            cnt         <= '0;
            mwb_valid   <= 1'b1;
            mwb_rd      <= lat_rd;
            mwb_wb_data <= 32'h0;
            bus_err     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven single-cycle vectors, directed multi-cycle
// sequences and randomized transactions checked against a byte-level model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        exm_valid;
  logic [31:0] exm_alu_result;
  logic [31:0] exm_store_data;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic        exm_mem_read;
  logic        exm_mem_write;
  logic [1:0]  exm_size;
  logic        exm_unsigned;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mwb_valid;
  logic [4:0]  mwb_rd;
  logic        mwb_reg_write;
  logic [31:0] mwb_wb_data;
  logic        misalign_err;
  logic        bus_err;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic sb_on = 1'b0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .exm_valid(exm_valid), .exm_alu_result(exm_alu_result),
    .exm_store_data(exm_store_data), .exm_rd(exm_rd),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_mem_write(exm_mem_write), .exm_size(exm_size),
    .exm_unsigned(exm_unsigned), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mwb_valid(mwb_valid), .mwb_rd(mwb_rd),
    .mwb_reg_write(mwb_reg_write), .mwb_wb_data(mwb_wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // Clock
  always #5 Clk = ~Clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  // An access is legal when its size is 1/2/4 bytes and the address is a multiple of it.
  function automatic logic model_bad(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'b11) return 1'b1;
    return (int'(a[1:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(a[1:0]) && i < int'(a[1:0]) + nbytes(size)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(size)) +: 8];
    return w;
  endfunction

  // Gather the accessed bytes little-endian, then apply two's-complement sign.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rdata);
    longint v;
    int n;
    v = 0;
    n = nbytes(size);
    for (int k = 0; k < n; k++)
      v += longint'(rdata[8*(int'(a[1:0]) + k) +: 8]) << (8*k);
    if (!uns && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle;
    exm_valid = 1'b0; exm_alu_result = '0; exm_store_data = '0; exm_rd = '0;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_mem_write = 1'b0;
    exm_size = 2'b00; exm_unsigned = 1'b0;
  endtask

  task automatic drive_op(input logic v, input logic rdm, input logic wrm,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd, input logic rw);
    exm_valid = v; exm_mem_read = rdm; exm_mem_write = wrm; exm_size = size;
    exm_unsigned = uns; exm_alu_result = a; exm_store_data = d; exm_rd = rd;
    exm_reg_write = rw;
  endtask

  // Aligned memory access acked in the delay-th request cycle (0 = first).
  task automatic mem_txn(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw,
                         input int delay, input logic [31:0] rdata);
    int stall_cyc;
    logic [31:0] exp_load;
    stall_cyc = 0;
    exp_load = model_load(size, uns, a, rdata);
    drive_op(1'b1, !wr, wr, size, uns, a, d, rd, rw);
    #1;
    check("launch_stall", 32'(stall), 32'd1);
    stall_cyc += int'(stall);
    tick;
    for (int c = 0; c <= delay; c++) begin
      // Upstream garbage while the access is outstanding must be ignored.
      drive_op(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0, $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'b1);
      check("req_high", 32'(dmem_req), 32'd1);
      check("req_addr", dmem_addr, {a[31:2], 2'b00});
      check("req_be", 32'(dmem_be), 32'(model_be(size, a)));
      check("req_we", 32'(dmem_we), 32'(wr));
      if (wr) check("req_wdata", dmem_wdata, model_wdata(size, d));
      if (c == delay) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      stall_cyc += int'(stall);
      check("req_stall", 32'(stall), (c != delay) ? 32'd1 : 32'd0);
      tick;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
    end
    set_idle;
    if (sb_on && !wr && rw) exp_q.push_back({rd, exp_load});
    check("stall_cycles", 32'(stall_cyc), 32'(delay + 1));
    check("req_drop", 32'(dmem_req), 32'd0);
    check("done_valid", 32'(mwb_valid), 32'd1);
    check("done_rd", 32'(mwb_rd), 32'(rd));
    check("done_rw", 32'(mwb_reg_write), 32'(!wr && rw));
    if (!wr) check("load_data", mwb_wb_data, exp_load);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge Clk) begin
    if (sb_on && mwb_valid && mwb_reg_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rd %0d data 0x%08h, expected no write-back", mwb_rd, mwb_wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({mwb_rd, mwb_wb_data} !== e) begin
          errors++;
          $display("FAIL sb_wb: got rd %0d data 0x%08h, expected rd %0d data 0x%08h",
                   mwb_rd, mwb_wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    logic        v;
    logic        rdm;
    logic        wrm;
    logic [1:0]  size;
    logic [31:0] a;
    logic [4:0]  rd;
    logic        rw;
    logic        e_valid;
    logic        e_rw;
    logic        e_mis;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1234, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_5555, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0101, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0003, 5'd4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0202, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0000, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset
    set_idle;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    Rst_n = 1'b0;
    tick;
    tick;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_mwb", {mwb_valid, mwb_reg_write, mwb_rd, misalign_err, bus_err}, 32'd0);
    check("rst_wb_data", mwb_wb_data, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    Rst_n = 1'b1;
    tick;

    // Table: single-cycle paths (ALU ops, bubbles, misaligned/illegal accesses)
    for (int i = 0; i < 8; i++) begin
      drive_op(vecs[i].v, vecs[i].rdm, vecs[i].wrm, vecs[i].size, 1'b0,
               vecs[i].a, 32'h1357_9BDF, vecs[i].rd, vecs[i].rw);
      #1;
      check("tbl_stall", 32'(stall), 32'd0);
      tick;
      set_idle;
      check("tbl_req", 32'(dmem_req), 32'd0);
      check("tbl_valid", 32'(mwb_valid), 32'(vecs[i].e_valid));
      check("tbl_mis", 32'(misalign_err), 32'(vecs[i].e_mis));
      check("tbl_bus", 32'(bus_err), 32'd0);
      if (vecs[i].e_valid) begin
        check("tbl_rd", 32'(mwb_rd), 32'(vecs[i].rd));
        check("tbl_rw", 32'(mwb_reg_write), 32'(vecs[i].e_rw));
      end
      if (vecs[i].chk_data) check("tbl_data", mwb_wb_data, vecs[i].e_data);
      tick;
      check("tbl_pulse_end", {mwb_valid, misalign_err}, 32'd0);
    end

    // Load byte signed at 0x103, ack 3 cycles after the request rises
    mem_txn(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 3, 32'h80FF_FFFF);
    check("lb_value", mwb_wb_data, 32'hFFFF_FF80);
    tick;

    // Store half 0xABCD at 0x202, acked in the first request cycle
    mem_txn(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd10, 1'b1, 0, 32'h0);
    tick;

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
    check("idle_ack", {mwb_valid, dmem_req, state_dbg}, 32'd0);

    // Timeout: load word never acked
    drive_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd7, 1'b1);
    #1;
    check("to_launch_stall", 32'(stall), 32'd1);
    tick;
    set_idle;
    for (int c = 0; c < int'(TO); c++) begin
      check("to_req", 32'(dmem_req), 32'd1);
      #1;
      check("to_stall", 32'(stall), (c < int'(TO) - 1) ? 32'd1 : 32'd0);
      tick;
    end
    check("to_req_drop", 32'(dmem_req), 32'd0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_valid", 32'(mwb_valid), 32'd1);
    check("to_rw", 32'(mwb_reg_write), 32'd0);
    check("to_state", 32'(state_dbg), 32'd0);
    check("to_stall_after", 32'(stall), 32'd0);
    tick;
    check("to_pulse_end", {bus_err, mwb_valid}, 32'd0);

    // Reset in the middle of an outstanding request; late ack is ignored
    drive_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 5'd12, 1'b1);
    tick;
    set_idle;
    tick;
    check("mid_req", 32'(dmem_req), 32'd1);
    Rst_n = 1'b0;
    tick;
    Rst_n = 1'b1;
    check("mid_rst_outs", {dmem_req, dmem_we, dmem_be, mwb_valid, mwb_reg_write, misalign_err, bus_err}, 32'd0);
    check("mid_rst_addr", dmem_addr, 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick;
    dmem_ack = 1'b0;
    check("late_ack", {mwb_valid, dmem_req, state_dbg, mwb_reg_write}, 32'd0);
    tick;
    check("late_ack2", 32'(mwb_valid), 32'd0);

    // Randomized traffic against the model and scoreboard
    sb_on = 1'b1;
    repeat (60) begin
      logic [1:0]  size;
      logic [31:0] a;
      logic [4:0]  rd;
      logic        rw;
      rd = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        drive_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, a, 32'h0, rd, rw);
        if (rw) exp_q.push_back({rd, a});
        #1;
        check("rnd_alu_stall", 32'(stall), 32'd0);
        tick;
        set_idle;
        check("rnd_alu_valid", 32'(mwb_valid), 32'd1);
      end else begin
        logic wr;
        wr = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1 && size != 2'b11) a = a & ~32'(nbytes(size) - 1);
        if (model_bad(size, a)) begin
          drive_op(1'b1, !wr, wr, size, 1'b0, a, $urandom, rd, rw);
          #1;
          check("rnd_mis_stall", 32'(stall), 32'd0);
          tick;
          set_idle;
          check("rnd_mis_err", 32'(misalign_err), 32'd1);
          check("rnd_mis_rw", {mwb_valid, mwb_reg_write, dmem_req}, 32'b100);
        end else begin
          mem_txn(wr, size, 1'($urandom_range(0, 1)), a, $urandom, rd, rw,
                  int'($urandom_range(0, TO - 1)), $urandom);
        end
      end
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;
    tick;
    sb_on = 1'b0;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
